microstepper_chopper_timers: RTL and testbench

//  Per-bridge timing engine for the fixed-off-time peak-current chopper; one channel each for bridge A and bridge B.
//  - Consumes the off-time start pulses offtimer_en0/1 from the microstepper control stage.
//  - Produces the off, blank and minimum-on countdowns that the control stage uses for:

---
 rtl/microstepper_pkg.sv | 26 ++
 rtl/microstepper_chopper_timers_if.sv | 33 +++
 rtl/chopper_timer_channel.sv | 70 +++++++
 rtl/microstepper_chopper_timers.sv | 79 +++++++
 tb/tb_microstepper_chopper_timers.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/microstepper_pkg.sv
// rtl/microstepper_pkg.sv - shared widths, bridge indices and channel state helper
package microstepper_pkg;

  localparam int OFFTIMER_W   = 10;
  localparam int BLANKTIMER_W = 8;
  localparam int MINONTIMER_W = 8;
  localparam int PHASE_W      = 8;

  localparam int BRIDGE_A = 0;
  localparam int BRIDGE_B = 1;

  typedef enum logic [1:0] {
    CH_ON,
    CH_BLANK,
    CH_OFF
  } chan_state_e;

  // Channel state is implied by the timers themselves; no separate register.
  function automatic chan_state_e chan_state(input logic [OFFTIMER_W-1:0]   off,
                                             input logic [BLANKTIMER_W-1:0] blank);
    if (off != '0)   return CH_OFF;
    if (blank != '0) return CH_BLANK;
    return CH_ON;
  endfunction

endpackage

// File: rtl/microstepper_chopper_timers_if.sv
// rtl/microstepper_chopper_timers_if.sv - control-stage side bundle for the chopper timers
interface microstepper_chopper_timers_if;
  import microstepper_pkg::*;

  logic                    enable;
  logic [PHASE_W-1:0]      phase_ct;
  logic                    offtimer_en0;
  logic                    offtimer_en1;
  logic [OFFTIMER_W-1:0]   config_offtime;
  logic [BLANKTIMER_W-1:0] config_blanktime;
  logic [MINONTIMER_W-1:0] config_minimum_on_time;
  logic [OFFTIMER_W-1:0]   off_timer0;
  logic [OFFTIMER_W-1:0]   off_timer1;
  logic [BLANKTIMER_W-1:0] blank_timer0;
  logic [BLANKTIMER_W-1:0] blank_timer1;
  logic [MINONTIMER_W-1:0] minimum_on_timer0;
  logic [MINONTIMER_W-1:0] minimum_on_timer1;

  modport master (
    output enable, phase_ct, offtimer_en0, offtimer_en1,
           config_offtime, config_blanktime, config_minimum_on_time,
    input  off_timer0, off_timer1, blank_timer0, blank_timer1,
           minimum_on_timer0, minimum_on_timer1
  );

  modport slave (
    input  enable, phase_ct, offtimer_en0, offtimer_en1,
           config_offtime, config_blanktime, config_minimum_on_time,
    output off_timer0, off_timer1, blank_timer0, blank_timer1,
           minimum_on_timer0, minimum_on_timer1
  );

endinterface

// File: rtl/chopper_timer_channel.sv
// rtl/chopper_timer_channel.sv - off/blank/minimum-on countdowns for one bridge
module chopper_timer_channel
  import microstepper_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_i,
  input  logic                    start_i,
  input  logic                    step_i,
  input  logic                    enable_i,
  input  logic                    enable_rise_i,
  input  logic [OFFTIMER_W-1:0]   cfg_offtime_i,
  input  logic [BLANKTIMER_W-1:0] cfg_blanktime_i,
  input  logic [MINONTIMER_W-1:0] cfg_minimum_on_time_i,
  output logic [OFFTIMER_W-1:0]   off_timer_o,
  output logic [BLANKTIMER_W-1:0] blank_timer_o,
  output logic [MINONTIMER_W-1:0] minimum_on_timer_o
);

  logic [OFFTIMER_W-1:0]   off_q,   off_d;
  logic [BLANKTIMER_W-1:0] blank_q, blank_d;
  logic [MINONTIMER_W-1:0] minon_q, minon_d;
  logic                    decay;
  logic                    expire;
  logic                    start_ok;

  assign decay    = (chan_state(off_q, blank_q) == CH_OFF);
  assign expire   = tick_i && (off_q == OFFTIMER_W'(1));
  assign start_ok = start_i && !decay;

  // Priority: disable > expiry (or zero-length start) > off load > blank reload.
  always_comb begin
    off_d   = off_q;
    blank_d = blank_q;
    minon_d = minon_q;
    if (tick_i && off_q != '0)   off_d   = off_q - 1'b1;
    if (tick_i && blank_q != '0) blank_d = blank_q - 1'b1;
    if (tick_i && minon_q != '0) minon_d = minon_q - 1'b1;
    if (!enable_i) begin
      off_d   = '0;
      blank_d = '0;
      minon_d = '0;
    end else if (expire || (start_ok && cfg_offtime_i == '0)) begin
      off_d   = '0;
      blank_d = cfg_blanktime_i;
      minon_d = cfg_minimum_on_time_i;
    end else if (start_ok) begin
      off_d = cfg_offtime_i;
    end else if (enable_rise_i || (step_i && !decay)) begin
      blank_d = cfg_blanktime_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_q   <= '0;
      blank_q <= '0;
      minon_q <= '0;
    end else begin
      off_q   <= off_d;
      blank_q <= blank_d;
      minon_q <= minon_d;
    end
  end

  assign off_timer_o        = off_q;
  assign blank_timer_o      = blank_q;
  assign minimum_on_timer_o = minon_q;

endmodule

// File: rtl/microstepper_chopper_timers.sv
// rtl/microstepper_chopper_timers.sv - shared prescaler, step and enable-edge detect for two chopper channels
module microstepper_chopper_timers
  import microstepper_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input logic                          clk,
  input logic                          reset,
  microstepper_chopper_timers_if.slave bus
);

  localparam int PRESC_W = 10;

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [PHASE_W-1:0]      phase_q;
  logic                    phase_vld_q;
  logic                    enable_q;
  logic                    tick;
  logic                    step;
  logic                    enable_rise;
  logic [1:0]              start;
  logic [OFFTIMER_W-1:0]   off_t   [2];
  logic [BLANKTIMER_W-1:0] blank_t [2];
  logic [MINONTIMER_W-1:0] minon_t [2];

  assign tick = (presc_q == PRESC_W'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) presc_d = '0;
  end

  // Prescaler and phase history keep running while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      phase_q     <= bus.phase_ct;
      phase_vld_q <= 1'b1;
      enable_q    <= bus.enable;
    end
  end

  assign step        = phase_vld_q && (bus.phase_ct != phase_q);
  assign enable_rise = bus.enable && !enable_q;

  assign start[BRIDGE_A] = bus.offtimer_en0;
  assign start[BRIDGE_B] = bus.offtimer_en1;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    chopper_timer_channel u_ch (
      .clk                   (clk),
      .reset                 (reset),
      .tick_i                (tick),
      .start_i               (start[g]),
      .step_i                (step),
      .enable_i              (bus.enable),
      .enable_rise_i         (enable_rise),
      .cfg_offtime_i         (bus.config_offtime),
      .cfg_blanktime_i       (bus.config_blanktime),
      .cfg_minimum_on_time_i (bus.config_minimum_on_time),
      .off_timer_o           (off_t[g]),
      .blank_timer_o         (blank_t[g]),
      .minimum_on_timer_o    (minon_t[g])
    );
  end

  assign bus.off_timer0        = off_t[BRIDGE_A];
  assign bus.off_timer1        = off_t[BRIDGE_B];
  assign bus.blank_timer0      = blank_t[BRIDGE_A];
  assign bus.blank_timer1      = blank_t[BRIDGE_B];
  assign bus.minimum_on_timer0 = minon_t[BRIDGE_A];
  assign bus.minimum_on_timer1 = minon_t[BRIDGE_B];

endmodule

// File: tb/tb_microstepper_chopper_timers.sv
// tb/tb_microstepper_chopper_timers.sv - scoreboard bench for the chopper timers at TICK_DIV 1 and 4
module tb_microstepper_chopper_timers;
  import microstepper_pkg::*;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  microstepper_chopper_timers_if ifa ();
  microstepper_chopper_timers_if ifb ();

  microstepper_chopper_timers #(.TICK_DIV(1)) dut_a (.clk(clk), .reset(reset_a), .bus(ifa));
  microstepper_chopper_timers #(.TICK_DIV(4)) dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sel: 0..5 = dut_a {off0,blank0,min0,off1,blank1,min1}, 6..11 = same for dut_b
  function automatic int dut_val(input int sel);
    case (sel)
      0:  return int'(ifa.off_timer0);
      1:  return int'(ifa.blank_timer0);
      2:  return int'(ifa.minimum_on_timer0);
      3:  return int'(ifa.off_timer1);
      4:  return int'(ifa.blank_timer1);
      5:  return int'(ifa.minimum_on_timer1);
      6:  return int'(ifb.off_timer0);
      7:  return int'(ifb.blank_timer0);
      8:  return int'(ifb.minimum_on_timer0);
      9:  return int'(ifb.off_timer1);
      10: return int'(ifb.blank_timer1);
      default: return int'(ifb.minimum_on_timer1);
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input int v, input string n);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic exp3(input int c, input int base, input int off, input int blank,
                      input int minon, input string n);
    expect_at(c, base,     off,   {n, "_off"});
    expect_at(c, base + 1, blank, {n, "_blank"});
    expect_at(c, base + 2, minon, {n, "_minon"});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        int act;
        act = dut_val(sb[i].sel);
        n_tests++;
        if (act != sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d actual=%0d expected=%0d", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    ifa.enable = 1'b0;
    ifa.phase_ct = 8'd3;
    ifa.offtimer_en0 = 1'b0;
    ifa.offtimer_en1 = 1'b0;
    ifa.config_offtime = 10'd700;
    ifa.config_blanktime = 8'd20;
    ifa.config_minimum_on_time = 8'd50;
    ifb.enable = 1'b0;
    ifb.phase_ct = 8'd3;
    ifb.offtimer_en0 = 1'b0;
    ifb.offtimer_en1 = 1'b0;
    ifb.config_offtime = 10'd3;
    ifb.config_blanktime = 8'd20;
    ifb.config_minimum_on_time = 8'd50;

    for (int c = 1; c <= 3; c++) begin
      exp3(c, 0, 0, 0, 0, "reset_a0");
      exp3(c, 3, 0, 0, 0, "reset_a1");
    end

    wait_to(3);
    reset_a = 1'b0;
    reset_b = 1'b0;
    ifa.enable = 1'b1;
    ifb.enable = 1'b1;
    exp3(4, 0, 0, 20, 0, "en_rise_a0");
    exp3(4, 3, 0, 20, 0, "en_rise_a1");
    expect_at(14, 1, 10, "blank_count");
    expect_at(23, 1, 1, "blank_last");
    exp3(24, 0, 0, 0, 0, "blank_done_a0");
    exp3(24, 3, 0, 0, 0, "blank_done_a1");

    wait_to(30);
    ifa.offtimer_en0 = 1'b1;
    exp3(31, 0, 700, 0, 0, "off_load");
    expect_at(32, 0, 699, "off_dec");
    exp3(730, 0, 1, 0, 0, "off_last");
    exp3(731, 0, 0, 20, 50, "off_expiry");
    exp3(31, 3, 0, 0, 0, "ch1_idle_load");
    exp3(731, 3, 0, 0, 0, "ch1_idle_expiry");
    wait_to(31);
    ifa.offtimer_en0 = 1'b0;

    wait_to(755);
    ifa.offtimer_en0 = 1'b1;
    exp3(756, 0, 700, 0, 25, "fault_window");
    exp3(757, 0, 699, 0, 24, "fault_min_count");
    exp3(781, 0, 675, 0, 0, "fault_min_zero");
    wait_to(756);
    ifa.offtimer_en0 = 1'b0;

    wait_to(799);
    ifa.offtimer_en0 = 1'b1;
    expect_at(800, 0, 656, "start_ignored");
    expect_at(801, 0, 655, "start_ignored_next");
    exp3(1456, 0, 0, 20, 50, "second_expiry");
    wait_to(800);
    ifa.offtimer_en0 = 1'b0;

    wait_to(1490);
    ifa.phase_ct = 8'd4;
    exp3(1491, 0, 0, 20, 15, "step_reload");
    expect_at(1491, 4, 20, "step_ch1_blank");
    expect_at(1491, 5, 0, "step_ch1_minon");

    wait_to(1499);
    ifa.offtimer_en0 = 1'b1;
    exp3(1500, 0, 700, 11, 6, "start_in_blank");
    wait_to(1500);
    ifa.offtimer_en0 = 1'b0;

    wait_to(1504);
    ifa.phase_ct = 8'd5;
    exp3(1505, 0, 695, 6, 1, "step_in_off");
    expect_at(1505, 4, 20, "step_ch1_again");
    exp3(2199, 0, 1, 0, 0, "pre_third_expiry");
    exp3(2200, 0, 0, 20, 50, "third_expiry");

    wait_to(2260);
    ifa.config_offtime = 10'd0;
    ifa.offtimer_en0 = 1'b1;
    exp3(2261, 0, 0, 20, 50, "zero_offtime");
    exp3(2262, 0, 0, 19, 49, "zero_offtime_next");
    exp3(2261, 3, 0, 0, 0, "zero_offtime_ch1");
    wait_to(2261);
    ifa.offtimer_en0 = 1'b0;
    ifa.config_offtime = 10'd700;

    wait_to(2300);
    ifa.offtimer_en0 = 1'b1;
    exp3(2601, 0, 400, 0, 0, "pre_disable");
    wait_to(2301);
    ifa.offtimer_en0 = 1'b0;

    wait_to(2601);
    ifa.enable = 1'b0;
    exp3(2602, 0, 0, 0, 0, "disabled_a0");
    exp3(2602, 3, 0, 0, 0, "disabled_a1");
    wait_to(2604);
    ifa.offtimer_en0 = 1'b1;
    exp3(2605, 0, 0, 0, 0, "no_load_disabled");
    wait_to(2605);
    ifa.offtimer_en0 = 1'b0;
    wait_to(2606);
    ifa.phase_ct = 8'd6;
    exp3(2608, 0, 0, 0, 0, "no_step_disabled_a0");
    exp3(2608, 3, 0, 0, 0, "no_step_disabled_a1");

    wait_to(2620);
    ifa.enable = 1'b1;
    exp3(2621, 0, 0, 20, 0, "re_enable_a0");
    exp3(2621, 3, 0, 20, 0, "re_enable_a1");

    wait_to(2624);
    ifa.offtimer_en0 = 1'b1;
    exp3(2625, 0, 700, 16, 0, "pre_reset_load");
    expect_at(2631, 4, 10, "blank1_at_10");
    wait_to(2625);
    ifa.offtimer_en0 = 1'b0;

    wait_to(2631);
    reset_a = 1'b1;
    exp3(2632, 0, 0, 0, 0, "mid_reset_a0");
    exp3(2632, 3, 0, 0, 0, "mid_reset_a1");
    wait_to(2633);
    ifa.offtimer_en0 = 1'b1;
    exp3(2634, 0, 0, 0, 0, "no_load_reset");
    wait_to(2634);
    ifa.offtimer_en0 = 1'b0;
    exp3(2636, 0, 0, 0, 0, "still_reset");
    wait_to(2636);
    reset_a = 1'b0;
    exp3(2637, 0, 0, 20, 0, "post_reset_a0");
    exp3(2637, 3, 0, 20, 0, "post_reset_a1");

    // dut_b ticks on cycles 7, 11, 15, ...; the load edge lands on a tick.
    wait_to(3002);
    ifb.offtimer_en1 = 1'b1;
    expect_at(3003, 9, 3, "presc_load");
    expect_at(3006, 9, 3, "presc_hold3");
    expect_at(3007, 9, 2, "presc_dec2");
    expect_at(3010, 9, 2, "presc_hold2");
    expect_at(3011, 9, 1, "presc_dec1");
    expect_at(3014, 9, 1, "presc_hold1");
    exp3(3015, 9, 0, 20, 50, "presc_expiry");
    expect_at(3018, 10, 20, "presc_blank_hold");
    expect_at(3019, 10, 19, "presc_blank_dec");
    exp3(3015, 6, 0, 0, 0, "presc_ch0_idle");
    wait_to(3003);
    ifb.offtimer_en1 = 1'b0;

    wait_to(3030);
    #6;
    n_tests++;
    if (ifa.off_timer0 != 10'd0) begin
        n_fail++;
        $display("FAIL final_a_off0 actual=%0d expected=0", ifa.off_timer0);
    end
    n_tests++;
    if (ifa.off_timer1 != 10'd0) begin
        n_fail++;
        $display("FAIL final_a_off1 actual=%0d expected=0", ifa.off_timer1);
    end
    n_tests++;
    if (ifa.minimum_on_timer0 != 8'd0) begin
        n_fail++;
        $display("FAIL final_a_min0 actual=%0d expected=0", ifa.minimum_on_timer0);
    end
    n_tests++;
    if (ifb.off_timer1 != 10'd0) begin
        n_fail++;
        $display("FAIL final_b_off1 actual=%0d expected=0", ifb.off_timer1);
    end
    n_tests++;
    if (ifb.off_timer0 != 10'd0) begin
        n_fail++;
        $display("FAIL final_b_off0 actual=%0d expected=0", ifb.off_timer0);
    end
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s never_checked cyc=%0d expected=%0d", sb[i].name, sb[i].cyc, sb[i].val);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
